// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//   Single-cycle class (ADD/SUB/AND/OR/XOR/SLT/SLTU/unused opcodes) has
//   latency 1. MUL/MULHU use shift-add and DIVU/REMU use restoring divide,
//   one iteration per cycle, for a latency of WIDTH+1. The result is
//   registered and held until out_ready.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in1, in2, sl          operands and opcode, qualified by in_valid
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   out, zero, sign       registered result and its flags
//   out_valid / out_ready result handshake
//   busy                  operation in flight or result pending
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       sl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;      // low opcode bits pick MUL/MULHU/DIVU/REMU
  logic [CNT_W-1:0] cnt;
  // {hi, lo}: product accumulator for multiply; {remainder, quotient} for divide
  logic [WIDTH-1:0] hi, lo, hi_n, lo_n;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] alu_res, iter_res;
  logic             accept, iter_op, last;

  assign accept  = in_valid && (state == IDLE);
  assign iter_op = (sl[3:2] == 2'b10);
  assign last    = (cnt == CNT_W'(1));

  // single-cycle class, computed straight from the inputs at accept
  always_comb begin
    alu_res = '0;
    case (sl)
      4'b0000: alu_res = in1 + in2;
      4'b0001: alu_res = in1 - in2;
      4'b0010: alu_res = in1 & in2;
      4'b0011: alu_res = in1 | in2;
      4'b0100: alu_res = in1 ^ in2;
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      4'b0110: alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
      default: alu_res = '0;
    endcase
  end

  // one iteration of multiply or divide
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (op_q[1]) begin
      // remainder stays below divisor, so a clear top bit means "fits".
      // Divisor 0 always fits: quotient all-ones, remainder = dividend.
      if (!div_diff[WIDTH]) {hi_n, lo_n} = {div_diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      else                  {hi_n, lo_n} = {div_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end else begin
      // carry out of the add shifts into the top of the accumulator
      {hi_n, lo_n} = {mul_sum, lo[WIDTH-1:1]};
    end
    iter_res = op_q[0] ? hi_n : lo_n;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = iter_op ? BUSY : DONE;
      BUSY:    if (last) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      out  <= '0;
      zero <= 1'b0;
      sign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q  <= in1;
          b_q  <= in2;
          op_q <= sl[1:0];
          if (iter_op) begin
            hi  <= '0;
            lo  <= sl[1] ? in1 : in2;  // dividend or multiplier
            cnt <= CNT_W'(WIDTH);
          end else begin
            out  <= alu_res;
            zero <= (alu_res == '0);
            sign <= alu_res[WIDTH-1];
          end
        end
        BUSY: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            out  <= iter_res;
            zero <= (iter_res == '0);
            sign <= iter_res[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a32, b32, o32;
  logic [3:0]  sl32;
  logic        iv32, ir32, z32, s32, ov32, or32, bz32;
  logic [7:0]  a8, b8, o8;
  logic [3:0]  sl8;
  logic        iv8, ir8, z8, s8, ov8, or8, bz8;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in1(a32), .in2(b32), .sl(sl32),
    .in_valid(iv32), .in_ready(ir32), .out(o32), .zero(z32), .sign(s32),
    .out_valid(ov32), .out_ready(or32), .busy(bz32));

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in1(a8), .in2(b8), .sl(sl8),
    .in_valid(iv8), .in_ready(ir8), .out(o8), .zero(z8), .sign(s8),
    .out_valid(ov8), .out_ready(or8), .busy(bz8));

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: plain arithmetic on w-bit unsigned values
  function automatic logic [63:0] ref_op(int w, logic [3:0] op, logic [63:0] a, logic [63:0] b);
    longint unsigned m, ua, ub;
    longint sa, sb;
    m  = (64'd1 << w) - 1;
    ua = a & m;
    ub = b & m;
    sa = ((ua >> (w - 1)) & 1) != 0 ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ((ub >> (w - 1)) & 1) != 0 ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    case (op)
      4'd0:    return (ua + ub) & m;
      4'd1:    return (ua - ub) & m;
      4'd2:    return ua & ub;
      4'd3:    return ua | ub;
      4'd4:    return ua ^ ub;
      4'd5:    return (sa < sb) ? 64'd1 : 64'd0;
      4'd6:    return (ua < ub) ? 64'd1 : 64'd0;
      4'd8:    return (ua * ub) & m;
      4'd9:    return ((ua * ub) >> w) & m;
      4'd10:   return (ub == 0) ? m : ua / ub;
      4'd11:   return (ub == 0) ? ua : ua % ub;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] g_out(bit n); return n ? 64'(o8) : 64'(o32); endfunction
  function automatic logic g_ov(bit n); return n ? ov8 : ov32; endfunction
  function automatic logic g_ir(bit n); return n ? ir8 : ir32; endfunction
  function automatic logic g_bz(bit n); return n ? bz8 : bz32; endfunction
  function automatic logic g_z(bit n);  return n ? z8 : z32; endfunction
  function automatic logic g_s(bit n);  return n ? s8 : s32; endfunction

  task automatic drive(bit n, logic [63:0] a, logic [63:0] b, logic [3:0] op, logic v);
    if (n) begin a8 = a[7:0]; b8 = b[7:0]; sl8 = op; iv8 = v; end
    else begin a32 = a[31:0]; b32 = b[31:0]; sl32 = op; iv32 = v; end
  endtask

  task automatic set_iv(bit n, logic v); if (n) iv8 = v; else iv32 = v; endtask
  task automatic set_or(bit n, logic v); if (n) or8 = v; else or32 = v; endtask

  // issue one op, measure latency, check result/flags, hold, release
  task automatic run(bit n, logic [3:0] op, logic [63:0] a, logic [63:0] b, int hold, bit pulse);
    int w, lat, cyc;
    logic [63:0] e;
    w   = n ? 8 : 32;
    e   = ref_op(w, op, a, b);
    lat = (op >= 4'd8 && op <= 4'd11) ? w + 1 : 1;
    @(negedge clk);
    chk("in_ready_idle", 64'(g_ir(n)), 64'd1);
    drive(n, a, b, op, 1'b1);
    @(negedge clk);
    cyc = 1;
    // scramble the inputs after accept; they must not matter
    drive(n, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 1'b0);
    while (!g_ov(n) && cyc < 100) begin
      chk("in_ready_busy", 64'(g_ir(n)), 64'd0);
      chk("busy_busy", 64'(g_bz(n)), 64'd1);
      if (pulse) set_iv(n, 1'($urandom_range(0, 1)));
      @(negedge clk);
      cyc++;
    end
    set_iv(n, 1'b0);
    chk($sformatf("latency op%0d w%0d", op, w), 64'(cyc), 64'(lat));
    chk($sformatf("out op%0d w%0d a=%0h b=%0h", op, w, a, b), g_out(n), e);
    chk("zero", 64'(g_z(n)), 64'(e == 0));
    chk("sign", 64'(g_s(n)), (e >> (w - 1)) & 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_valid", 64'(g_ov(n)), 64'd1);
      chk("held_out", g_out(n), e);
      chk("held_in_ready", 64'(g_ir(n)), 64'd0);
    end
    set_or(n, 1'b1);
    @(negedge clk);
    set_or(n, 1'b0);
    chk("released_valid", 64'(g_ov(n)), 64'd0);
    chk("released_in_ready", 64'(g_ir(n)), 64'd1);
    chk("released_out_kept", g_out(n), e);
  endtask

  initial begin
    logic [3:0] ops [13];
    logic [63:0] ra, rb;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd7, 4'd15};
    drive(1'b0, 0, 0, 4'd0, 1'b0);
    drive(1'b1, 0, 0, 4'd0, 1'b0);
    or32 = 1'b0;
    or8  = 1'b0;
    #1;
    chk("rst_out", 64'(o32), 64'd0);
    chk("rst_zero", 64'(z32), 64'd0);
    chk("rst_sign", 64'(s32), 64'd0);
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_busy", 64'(bz32), 64'd0);
    chk("rst_out8", 64'(o8), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single-cycle class
    run(0, 4'd0, 5, 7, 0, 0);
    run(0, 4'd1, 3, 3, 0, 0);
    run(0, 4'd1, 0, 1, 0, 0);
    run(0, 4'd5, 32'hFFFF_FFFF, 1, 0, 0);
    run(0, 4'd6, 32'hFFFF_FFFF, 1, 0, 0);
    run(0, 4'd15, 32'h1234, 32'h5678, 0, 0);
    // iterative ops, held result and ignored in_valid pulses
    run(0, 4'd8, 7, 6, 3, 1);
    run(0, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    run(0, 4'd10, 100, 7, 0, 0);
    run(0, 4'd11, 100, 7, 0, 0);
    run(0, 4'd10, 9, 0, 0, 0);
    run(0, 4'd11, 9, 0, 0, 0);

    // reset during a divide abandons it
    @(negedge clk);
    drive(0, 1000, 3, 4'd10, 1'b1);
    @(negedge clk);
    set_iv(0, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", 64'(bz32), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(ov32), 64'd0);
    chk("mid_rst_out", 64'(o32), 64'd0);
    chk("mid_rst_busy", 64'(bz32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 4'd0, 1, 1, 0, 0);

    // narrow instance
    run(1, 4'd8, 8'h0F, 8'h11, 0, 0);
    run(1, 4'd10, 8'hFF, 8'h10, 0, 0);
    run(1, 4'd9, 8'hFF, 8'hFF, 0, 1);
    run(1, 4'd5, 8'h80, 8'h7F, 0, 0);

    // random
    for (int i = 0; i < 24; i++) begin
      ra = {32'd0, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : {32'd0, $urandom};
      run(i[0], ops[$urandom_range(0, 12)], ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU. Adds signed/unsigned compare, iterative shift-add multiply and restoring divide, and valid/ready handshakes on both operand and result sides, so a multi-cycle datapath controller can issue operations and stall on the result. Outputs are registered and held until consumed.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
sl  input  4  operation select
in_valid  input  1  operands/sl valid
in_ready  output  1  block can accept operation
out  output  WIDTH  result (registered)
zero  output  1  out == 0 (registered with out)
sign  output  1  out[WIDTH-1] (registered with out)
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE, out=0, zero=0, sign=0, out_valid=0, counter=0, operand regs=0; in_ready=1 after release. Reset mid-operation abandons the operation with no result.
- Opcodes: 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SLT (signed, result 1/0); 0110 SLTU (unsigned); 1000 MUL (low WIDTH bits of unsigned product); 1001 MULHU (high WIDTH bits); 1010 DIVU; 1011 REMU; others -> result 0, single-cycle class.
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE); busy = !IDLE; out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready, latch in1, in2, sl. Single-cycle class: compute from inputs and register out/zero/sign, go to DONE (out_valid high next cycle, latency 1). MUL/MULHU/DIVU/REMU: load iteration regs, counter=WIDTH, go to BUSY.
- BUSY: one iteration per cycle. MUL: 2*WIDTH-bit accumulator, add shifted multiplicand when multiplier LSB=1, shift. DIVU/REMU: restoring divide, one quotient bit per cycle MSB-first. When counter reaches 0 after final iteration, register result and flags, go DONE. Total latency from accept edge to out_valid: WIDTH+1 cycles.
- Divide by zero: no special-case timing (still WIDTH+1); DIVU result all-ones, REMU result = dividend.
- DONE: out/zero/sign stable while out_valid && !out_ready. On out_ready, go IDLE next cycle; out/zero/sign keep last value (do not clear) until next result.
- in1/in2/sl changes after accept have no effect. in_valid while not IDLE is ignored (not queued). Max throughput: one op per 2 cycles (single-cycle class).
- out_ready while not DONE: ignored.
- zero/sign always describe the registered out of the same operation (SLT result 1 -> zero=0, sign=0).

Test Plan:
- Reset then ADD 5+7 with out_ready=1 -> out_valid one cycle after accept, out=12, zero=0, sign=0; SUB 3-3 -> out=0, zero=1; SUB 0-1 -> 0xFFFFFFFF, sign=1.
- SLT in1=0xFFFFFFFF, in2=1 -> out=1; SLTU same operands -> out=0, zero=1; opcode 1111 -> out=0 after 1 cycle.
- MUL 7*6 with out_ready=0 for 3 cycles after out_valid -> out_valid exactly 33 cycles after accept (WIDTH=32), out=42 held stable, in_ready=0 throughout, in_valid pulses during BUSY ignored; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each latency 33.
- Assert rst_n low mid-BUSY (cycle 10 of a DIVU) -> immediately out_valid=0, out=0, busy=0; after release, ADD 1+1 -> 2 with normal latency.
- Parameter WIDTH=8: MUL 0x0F*0x11 -> out=0xFF, latency 9; DIVU 0xFF/0x10 -> 0x0F.
